// File: rtl/uart_rx_if.sv
// Receive-side UART signal bundle: baud tick and serial pin in, recovered byte and strobes out.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 b_tick;
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_done;
   logic                 rx_busy;
   logic                 frame_err;

   modport master (
      output b_tick, rx,
      input  rx_data, rx_done, rx_busy, frame_err
   );

   modport slave (
      input  b_tick, rx,
      output rx_data, rx_done, rx_busy, frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the synchronized rx line on the shared baud tick,
// samples each bit at its centre and hands completed bytes to the RX FIFO via rx_done.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input logic      clk,
   input logic      reset,
   uart_rx_if.slave bus
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic                 rx_meta;
   logic                 rx_s;

   logic [1:0]           state,     state_nxt;
   logic [TICK_W-1:0]    tick_cnt,  tick_nxt;
   logic [BIT_W-1:0]     bit_cnt,   bit_nxt;
   logic [DATA_BITS-1:0] shift_reg, shift_nxt;
   logic [DATA_BITS-1:0] data_reg,  data_nxt;
   logic                 busy_reg,  busy_nxt;
   logic                 done_reg,  done_nxt;
   logic                 ferr_reg,  ferr_nxt;

   // NOTE: both synchronizer flops reset to the idle-high line level so that
   // leaving reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      tick_nxt  = tick_cnt;
      bit_nxt   = bit_cnt;
      shift_nxt = shift_reg;
      data_nxt  = data_reg;
      busy_nxt  = busy_reg;
      done_nxt  = 1'b0;
      ferr_nxt  = 1'b0;

      case (state)
         IDLE: begin
            // Start detection is immediate; tick alignment begins in START.
            if (!rx_s) begin
               state_nxt = START;
               tick_nxt  = '0;
               busy_nxt  = 1'b1;
            end
         end

         START: begin
            if (bus.b_tick) begin
               if (tick_cnt == TICK_HALF) begin
                  if (!rx_s) begin
                     state_nxt = DATA;
                     tick_nxt  = '0;
                     bit_nxt   = '0;
                  end else begin
                     state_nxt = IDLE;
                     busy_nxt  = 1'b0;
                  end
               end else begin
                  tick_nxt = tick_cnt + TICK_W'(1);
               end
            end
         end

         DATA: begin
            if (bus.b_tick) begin
               if (tick_cnt == TICK_LAST) begin
                  shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
                  tick_nxt  = '0;
                  if (bit_cnt == BIT_LAST) begin
                     state_nxt = STOP;
                  end else begin
                     bit_nxt = bit_cnt + BIT_W'(1);
                  end
               end else begin
                  tick_nxt = tick_cnt + TICK_W'(1);
               end
            end
         end

         STOP: begin
            if (bus.b_tick) begin
               if (tick_cnt == TICK_LAST) begin
                  // Returning at mid stop bit leaves half a bit for the next start edge.
                  if (rx_s) begin
                     data_nxt = shift_reg;
                     done_nxt = 1'b1;
                  end else begin
                     ferr_nxt = 1'b1;
                  end
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
               end else begin
                  tick_nxt = tick_cnt + TICK_W'(1);
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         data_reg  <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         ferr_reg  <= 1'b0;
      end else begin
         state     <= state_nxt;
         tick_cnt  <= tick_nxt;
         bit_cnt   <= bit_nxt;
         shift_reg <= shift_nxt;
         data_reg  <= data_nxt;
         busy_reg  <= busy_nxt;
         done_reg  <= done_nxt;
         ferr_reg  <= ferr_nxt;
      end
   end

   assign bus.rx_data   = data_reg;
   assign bus.rx_done   = done_reg;
   assign bus.rx_busy   = busy_reg;
   assign bus.frame_err = ferr_reg;

endmodule
